// File: rtl/amem_pkg.sv
// Shared types and default geometry for the CADR A-memory.
package amem_pkg;

    localparam int AMEM_WIDTH = 32;
    localparam int AMEM_AW    = 10;

    typedef enum logic {
        AMEM_CLEAR,
        AMEM_IDLE
    } amem_state_e;

    // Which register currently drives the read-data output.
    typedef enum logic [1:0] {
        AMEM_SRC_ZERO,
        AMEM_SRC_RAM,
        AMEM_SRC_FWD
    } amem_src_e;

endpackage

// File: rtl/amem_ram.sv
// Plain simple-dual-port synchronous RAM: one write port, one registered read
// port, read-before-write on same-address collisions.
module amem_ram
    import amem_pkg::*;
#(
    parameter int WIDTH = AMEM_WIDTH,
    parameter int AW    = AMEM_AW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    // NOTE: non-blocking writes make a same-edge read see the old word, and
    // the array has no reset so it maps onto block RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/amem_dp.sv
// A-memory with clear sequencer, registered read port and optional
// same-address write forwarding (define AMEM_BYPASS_EN to enable it).
module amem_dp
    import amem_pkg::*;
#(
    parameter int WIDTH = AMEM_WIDTH,
    parameter int AW    = AMEM_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    raddr,
    input  logic             arp,
    output logic [WIDTH-1:0] amem,
    input  logic [AW-1:0]    waddr,
    input  logic             awp,
    input  logic [WIDTH-1:0] l,
    input  logic             clr,
    output logic             busy,
    output logic             clr_done
);

    localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    amem_state_e      state;
    amem_src_e        src;
    logic [AW:0]      cnt;
    logic             sweep;
    logic             fwd_hit;
    logic             ram_we;
    logic             ram_re;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    assign sweep = (state == AMEM_CLEAR);

    // The sweep owns the write port; host reads are blocked until it ends.
    always_comb begin
        ram_we    = sweep | awp;
        ram_waddr = sweep ? cnt[AW-1:0] : waddr;
        ram_wdata = sweep ? '0 : l;
        ram_re    = !sweep && arp;
    end

    amem_ram #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (ram_re),
        .raddr(raddr),
        .rdata(ram_rdata)
    );

`ifdef AMEM_BYPASS_EN
    logic [WIDTH-1:0] fwd_q;

    assign fwd_hit = awp && (waddr == raddr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_q <= '0;
        end else if (!sweep && arp && fwd_hit) begin
            fwd_q <= l;
        end
    end
`else
    assign fwd_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= AMEM_CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            clr_done <= 1'b0;
            src      <= AMEM_SRC_ZERO;
        end else begin
            clr_done <= 1'b0;
            case (state)
                AMEM_CLEAR: begin
                    src <= AMEM_SRC_ZERO;
                    if (cnt == LAST) begin
                        state    <= AMEM_IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                AMEM_IDLE: begin
                    if (arp) begin
                        src <= fwd_hit ? AMEM_SRC_FWD : AMEM_SRC_RAM;
                    end
                    if (clr) begin
                        state <= AMEM_CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= AMEM_CLEAR;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // NOTE: assign a default before the case so no path leaves amem unassigned
    // and a latch cannot be inferred.
    always_comb begin
        amem = '0;
        case (src)
            AMEM_SRC_RAM: amem = ram_rdata;
`ifdef AMEM_BYPASS_EN
            AMEM_SRC_FWD: amem = fwd_q;
`endif
            default:      amem = '0;
        endcase
    end

endmodule

// File: tb/tb_amem_dp.sv
// Self-checking bench for amem_dp (AW=4): array-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_amem_dp;

    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef AMEM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [AW-1:0]    raddr;
    logic             arp;
    logic [WIDTH-1:0] amem;
    logic [AW-1:0]    waddr;
    logic             awp;
    logic [WIDTH-1:0] l;
    logic             clr;
    logic             busy;
    logic             clr_done;

    always #5 clk = ~clk;

    amem_dp #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raddr   (raddr),
        .arp     (arp),
        .amem    (amem),
        .waddr   (waddr),
        .awp     (awp),
        .l       (l),
        .clr     (clr),
        .busy    (busy),
        .clr_done(clr_done)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: memory array, sweep index and expected outputs.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_amem;
    bit          m_busy;
    bit          m_done;
    int          m_idx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b1;
            m_idx  <= 0;
            m_amem <= 32'h0;
            m_done <= 1'b0;
        end else if (m_busy) begin
            m_mem[m_idx] <= 32'h0;
            m_amem       <= 32'h0;
            if (m_idx == DEPTH - 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_idx  <= m_idx + 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (arp) m_amem <= (BYPASS && awp && waddr == raddr) ? l : m_mem[raddr];
            if (awp) m_mem[waddr] <= l;
            if (clr) begin
                m_busy <= 1'b1;
                m_idx  <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("amem", amem, m_amem);
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("clr_done", {31'b0, clr_done}, {31'b0, m_done});
        end
    end

    task automatic step(input logic a, input logic [AW-1:0] ra, input logic w,
                        input logic [AW-1:0] wa, input logic [31:0] d, input logic c);
        arp = a; raddr = ra; awp = w; waddr = wa; l = d; clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        step(1'b0, 4'd0, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        step(1'b1, a, 1'b0, 4'd0, 32'h0, 1'b0);
        check(name, amem, exp);
    endtask

    // Count edges until busy falls; with noise, host writes/reads and a
    // mid-sweep clr are thrown at the sequencer.
    task automatic sweep_len(input string name, input bit noise);
        int cycles = 0;
        int dones  = 0;
        while (busy && cycles < 64) begin
            if (noise)
                step(1'($urandom_range(1)), 4'($urandom_range(15)), 1'b1,
                     4'($urandom_range(15)), $urandom(), cycles == 5);
            else
                idle(1);
            cycles++;
            if (clr_done) begin
                dones++;
                check({name, "_done_with_busy"}, {31'b0, busy}, 32'h0);
            end
        end
        check({name, "_cycles"}, cycles, 32'd16);
        check({name, "_dones"}, dones, 32'd1);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;

        arp = 1'b0; awp = 1'b0; clr = 1'b0;
        raddr = '0; waddr = '0; l = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checking = 1'b1;
        check("rst_amem", amem, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h1);
        check("rst_done", {31'b0, clr_done}, 32'h0);
        #2 reset = 1'b0;

        sweep_len("init", 1'b0);
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 32'h0, "init_zero");

        wr(4'd5, 32'hDEADBEEF);
        rd(4'd5, 32'hDEADBEEF, "rd5");
        repeat (3) begin
            idle(1);
            check("hold5", amem, 32'hDEADBEEF);
        end

        wr(4'd7, 32'hAAAA5555);
        step(1'b1, 4'd7, 1'b1, 4'd7, 32'h12345678, 1'b0);
        check("collide7", amem, BYPASS ? 32'h12345678 : 32'hAAAA5555);
        rd(4'd7, 32'h12345678, "rd7_after");

        wr(4'd4, 32'h2);
        step(1'b1, 4'd4, 1'b1, 4'd3, 32'h1, 1'b0);
        check("indep4", amem, 32'h2);
        rd(4'd3, 32'h1, "rd3");

        wr(4'd0, 32'h11111111);
        wr(4'd15, 32'hF0F0F0F0);
        rd(4'd15, 32'hF0F0F0F0, "pre15");
        step(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1);
        sweep_len("clr", 1'b1);
        rd(4'd0, 32'h0, "clr0");
        rd(4'd15, 32'h0, "clr15");
        rd(4'd5, 32'h0, "clr5");

        step(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1);
        idle(8);
        #2 reset = 1'b1;
        @(negedge clk);
        check("midrst_amem", amem, 32'h0);
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'h1);
        #2 reset = 1'b0;
        sweep_len("rst_mid", 1'b0);

        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(15));
            wa = ($urandom_range(3) == 0) ? ra : 4'($urandom_range(15));
            step(1'($urandom_range(1)), ra, 1'($urandom_range(1)), wa, $urandom(),
                 $urandom_range(99) == 0);
        end

        for (int i = 0; i < 64 && busy; i++) idle(1);
        check("drain_busy", {31'b0, busy}, 32'h0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
